fsb_initiator: RTL and testbench

Bus-cycle initiator for the MC68HC000-style front-side bus: the master-side counterpart to the FSB responder, which answers with DTACK/VPA. It accepts single-word transfer requests from an internal requester (DMA/accelerator path), then drives nAS, nUDS, nLDS and RnW. It completes on nDTACK, on nVPA (6800-style E-clock synchronous cycle with nVMA), or on nBERR/timeout, and returns read data plus status.

---
 rtl/fsb_pkg.sv | 28 ++
 rtl/fsb_initiator_if.sv | 45 ++++
 rtl/fsb_eclk.sv | 35 +++
 rtl/fsb_initiator.sv | 149 ++++++++++++++
 tb/tb_fsb_initiator.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fsb_pkg.sv
// fsb_pkg: shared definitions for the front-side-bus initiator and the
// 6800-style E-clock divider.
//   fsb_state_e     bus-cycle sequencer states
//   FSB_TIMEOUT_DEF default WAIT-state limit before an error termination
//   E_DIV_DEF       default E-clock period in FCLK cycles
//   E_HIGH_START    first divider phase with E high
//   VMA_PHASE       divider phase at which nVMA is asserted in a VPA cycle
//   be_norm         byte-enable normalisation (00 means both bytes)
package fsb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_VPA,
        ST_TERM
    } fsb_state_e;

    localparam int unsigned FSB_TIMEOUT_DEF = 255;
    localparam int unsigned E_DIV_DEF       = 10;
    localparam int unsigned E_HIGH_START    = 6;
    localparam int unsigned VMA_PHASE       = 2;

    function automatic logic [1:0] be_norm(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

endpackage

// File: rtl/fsb_initiator_if.sv
// fsb_initiator_if: groups the requester handshake and the 68000-style bus
// signals of the initiator.
//   Requester side: Req/ReqRdy, ReqA, ReqRnW, ReqBE, ReqWD, Ack, Err, RD
//   Bus side:       A, RnW, DOE, DOut, DIn, nAS, nUDS, nLDS,
//                   nDTACK, nVPA, nBERR, E, nVMA
//   master: the initiator's view; slave: requester plus responder view.
interface fsb_initiator_if;

    logic        Req;
    logic        ReqRdy;
    logic [22:0] ReqA;
    logic        ReqRnW;
    logic [1:0]  ReqBE;
    logic [15:0] ReqWD;
    logic        Ack;
    logic        Err;
    logic [15:0] RD;

    logic [22:0] A;
    logic        RnW;
    logic        DOE;
    logic [15:0] DOut;
    logic [15:0] DIn;
    logic        nAS;
    logic        nUDS;
    logic        nLDS;
    logic        nDTACK;
    logic        nVPA;
    logic        nBERR;
    logic        E;
    logic        nVMA;

    modport master (
        input  Req, ReqA, ReqRnW, ReqBE, ReqWD, DIn, nDTACK, nVPA, nBERR,
        output ReqRdy, Ack, Err, RD, A, RnW, DOE, DOut, nAS, nUDS, nLDS,
               E, nVMA
    );

    modport slave (
        output Req, ReqA, ReqRnW, ReqBE, ReqWD, DIn, nDTACK, nVPA, nBERR,
        input  ReqRdy, Ack, Err, RD, A, RnW, DOE, DOut, nAS, nUDS, nLDS,
               E, nVMA
    );

endinterface

// File: rtl/fsb_eclk.sv
// fsb_eclk: free-running 6800-style E-clock divider.
//   clk   in   clock
//   rst   in   synchronous reset, active-high (phase=0, e=0)
//   e     out  E clock, low for phases 0..HIGH_START-1, high afterwards
//   phase out  current divider phase, wraps EDIV-1 -> 0
module fsb_eclk
    import fsb_pkg::*;
#(
    parameter int unsigned EDIV       = E_DIV_DEF,
    parameter int unsigned HIGH_START = E_HIGH_START
) (
    input  logic       clk,
    input  logic       rst,
    output logic       e,
    output logic [7:0] phase
);

    logic [7:0] phase_nxt;

    always_comb begin
        phase_nxt = (phase == 8'(EDIV - 1)) ? '0 : phase + 8'd1;
    end

    // E is registered from the next phase so it stays aligned with phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            e     <= 1'b0;
        end else begin
            phase <= phase_nxt;
            e     <= (phase_nxt >= 8'(HIGH_START));
        end
    end

endmodule

// File: rtl/fsb_initiator.sv
// fsb_initiator: MC68HC000-style bus-cycle initiator. Accepts one word
// transfer per request and runs it on the bus, terminating on nDTACK,
// nVPA (E-clock synchronous cycle with nVMA), nBERR or WAIT timeout.
//   FCLK   in  bus clock
//   RESET  in  synchronous reset, active-high
//   bus    fsb_initiator_if.master: requester handshake plus bus signals
// All FSM outputs are registered: values computed in a state appear on the
// outputs during the following cycle.
module fsb_initiator
    import fsb_pkg::*;
#(
    parameter int unsigned TIMEOUT = FSB_TIMEOUT_DEF,
    parameter int unsigned EDIV    = E_DIV_DEF
) (
    input  logic                   FCLK,
    input  logic                   RESET,
    fsb_initiator_if.master        bus
);

    fsb_state_e  state;
    logic [1:0]  be;
    logic [7:0]  wcnt;
    logic        err_flag;
    logic        rd_load;
    logic [15:0] rd_buf;
    logic [7:0]  phase;
    logic        e_clk;

    fsb_eclk #(
        .EDIV       (EDIV),
        .HIGH_START (E_HIGH_START)
    ) u_eclk (
        .clk   (FCLK),
        .rst   (RESET),
        .e     (e_clk),
        .phase (phase)
    );

    assign bus.E = e_clk;

    always_ff @(posedge FCLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            bus.ReqRdy <= 1'b0;
            bus.Ack    <= 1'b0;
            bus.Err    <= 1'b0;
            bus.RD     <= '0;
            bus.A      <= '0;
            bus.RnW    <= 1'b1;
            bus.DOE    <= 1'b0;
            bus.DOut   <= '0;
            bus.nAS    <= 1'b1;
            bus.nUDS   <= 1'b1;
            bus.nLDS   <= 1'b1;
            bus.nVMA   <= 1'b1;
            be         <= 2'b11;
            wcnt       <= '0;
            err_flag   <= 1'b0;
            rd_load    <= 1'b0;
            rd_buf     <= '0;
        end else begin
            bus.Ack <= 1'b0;
            bus.Err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.ReqRdy && bus.Req) begin
                        bus.ReqRdy <= 1'b0;
                        bus.A      <= bus.ReqA;
                        bus.RnW    <= bus.ReqRnW;
                        bus.DOut   <= bus.ReqWD;
                        bus.DOE    <= !bus.ReqRnW;
                        be         <= be_norm(bus.ReqBE);
                        wcnt       <= '0;
                        err_flag   <= 1'b0;
                        rd_load    <= 1'b0;
                        state      <= ST_ADDR;
                    end else begin
                        bus.ReqRdy <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    bus.nAS <= 1'b0;
                    if (bus.RnW) begin
                        bus.nUDS <= !be[1];
                        bus.nLDS <= !be[0];
                    end
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Write data strobes trail nAS by one cycle so DOut has
                    // a full cycle of setup before the strobe.
                    if (!bus.RnW) begin
                        bus.nUDS <= !be[1];
                        bus.nLDS <= !be[0];
                    end
                    if (!bus.nBERR) begin
                        err_flag <= 1'b1;
                        state    <= ST_TERM;
                    end else if (!bus.nDTACK) begin
                        rd_buf  <= bus.DIn;
                        rd_load <= bus.RnW;
                        state   <= ST_TERM;
                    end else if (!bus.nVPA) begin
                        state <= ST_VPA;
                    end else if (wcnt == 8'(TIMEOUT - 1)) begin
                        err_flag <= 1'b1;
                        state    <= ST_TERM;
                    end else if (wcnt != '1) begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                ST_VPA: begin
                    // nVMA goes low together with divider phase VMA_PHASE;
                    // the transfer completes on the last E-high phase that
                    // follows it, never on one seen before nVMA.
                    if (!bus.nBERR) begin
                        err_flag <= 1'b1;
                        state    <= ST_TERM;
                    end else if (!bus.nVMA && phase == 8'(EDIV - 1)) begin
                        rd_buf  <= bus.DIn;
                        rd_load <= bus.RnW;
                        state   <= ST_TERM;
                    end else if (bus.nVMA && phase == 8'(VMA_PHASE - 1)) begin
                        bus.nVMA <= 1'b0;
                    end
                end
                ST_TERM: begin
                    bus.nAS    <= 1'b1;
                    bus.nUDS   <= 1'b1;
                    bus.nLDS   <= 1'b1;
                    bus.nVMA   <= 1'b1;
                    bus.DOE    <= 1'b0;
                    bus.Ack    <= 1'b1;
                    bus.Err    <= err_flag;
                    bus.ReqRdy <= 1'b1;
                    // RD only moves at Ack so it holds between completions.
                    if (rd_load) begin
                        bus.RD <= rd_buf;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsb_initiator.sv
// tb_fsb_initiator: directed self-checking bench for fsb_initiator with
// TIMEOUT=16, EDIV=10. Edge numbers in comments count from the edge at
// which the request is accepted (edge 0).
module tb_fsb_initiator;

    logic FCLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    int   div_m  = 0;

    always #5 FCLK = ~FCLK;

    fsb_initiator_if bus ();

    fsb_initiator #(
        .TIMEOUT (16),
        .EDIV    (10)
    ) dut (
        .FCLK  (FCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Reference E-divider phase, independent of the DUT.
    always @(posedge FCLK) begin
        if (RESET) div_m <= 0;
        else       div_m <= (div_m == 9) ? 0 : div_m + 1;
    end

    task automatic tick;
        @(posedge FCLK);
        #1;
    endtask

    task automatic start_req(input logic [22:0] a, input logic rnw,
                             input logic [1:0] be_in, input logic [15:0] wd);
        bus.ReqA   = a;
        bus.ReqRnW = rnw;
        bus.ReqBE  = be_in;
        bus.ReqWD  = wd;
        bus.Req    = 1'b1;
        tick;                               // edge 0: accepted
        bus.Req    = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick; tick; tick;
        checks++; if (bus.nAS !== 1'b1) begin errors++; $display("FAIL rst_nAS: got %b expected 1", bus.nAS); end
        checks++; if ({bus.nUDS, bus.nLDS, bus.nVMA} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b expected 111", {bus.nUDS, bus.nLDS, bus.nVMA}); end
        checks++; if ({bus.E, bus.Ack, bus.Err, bus.DOE, bus.ReqRdy} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 00000", {bus.E, bus.Ack, bus.Err, bus.DOE, bus.ReqRdy}); end
        checks++; if (bus.RnW !== 1'b1) begin errors++; $display("FAIL rst_RnW: got %b expected 1", bus.RnW); end
        checks++; if ({bus.A, bus.DOut, bus.RD} !== 55'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", {bus.A, bus.DOut, bus.RD}); end
        RESET = 1'b0;
        tick;
        checks++; if (bus.ReqRdy !== 1'b1) begin errors++; $display("FAIL rst_ReqRdy_after: got %b expected 1", bus.ReqRdy); end
    endtask

    task automatic test_read;
        bus.DIn = 16'h0000;
        start_req(23'h000100, 1'b1, 2'b11, 16'h0000);
        checks++; if (bus.A !== 23'h000100) begin errors++; $display("FAIL rd_A: got %h expected 000100", bus.A); end
        checks++; if ({bus.RnW, bus.DOE, bus.nAS, bus.ReqRdy} !== 4'b1010) begin errors++; $display("FAIL rd_addr_ctrl: got %b expected 1010", {bus.RnW, bus.DOE, bus.nAS, bus.ReqRdy}); end
        tick;                               // edge 1
        checks++; if ({bus.nAS, bus.nUDS, bus.nLDS} !== 3'b000) begin errors++; $display("FAIL rd_strobes: got %b expected 000", {bus.nAS, bus.nUDS, bus.nLDS}); end
        bus.nDTACK = 1'b0;
        bus.DIn    = 16'hBEEF;
        tick;                               // edge 2: into TERM
        checks++; if (bus.Ack !== 1'b0) begin errors++; $display("FAIL rd_ack_early: got %b expected 0", bus.Ack); end
        bus.nDTACK = 1'b1;
        bus.DIn    = 16'h0000;
        tick;                               // edge 3
        checks++; if ({bus.Ack, bus.Err} !== 2'b10) begin errors++; $display("FAIL rd_ack: got %b expected 10", {bus.Ack, bus.Err}); end
        checks++; if (bus.RD !== 16'hBEEF) begin errors++; $display("FAIL rd_RD: got %h expected BEEF", bus.RD); end
        checks++; if ({bus.nAS, bus.nUDS, bus.nLDS, bus.ReqRdy} !== 4'b1111) begin errors++; $display("FAIL rd_term: got %b expected 1111", {bus.nAS, bus.nUDS, bus.nLDS, bus.ReqRdy}); end
        tick;
        checks++; if ({bus.Ack, bus.RD} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL rd_hold: got %h expected 0BEEF", {bus.Ack, bus.RD}); end
    endtask

    task automatic test_write;
        start_req(23'h012345, 1'b0, 2'b10, 16'h1234);
        checks++; if ({bus.DOE, bus.RnW, bus.DOut} !== {2'b10, 16'h1234}) begin errors++; $display("FAIL wr_addr: got %h expected 21234", {bus.DOE, bus.RnW, bus.DOut}); end
        tick;                               // edge 1
        checks++; if ({bus.nAS, bus.nUDS, bus.nLDS} !== 3'b011) begin errors++; $display("FAIL wr_as_only: got %b expected 011", {bus.nAS, bus.nUDS, bus.nLDS}); end
        tick;                               // edge 2
        checks++; if ({bus.nAS, bus.nUDS, bus.nLDS, bus.DOE} !== 4'b0011) begin errors++; $display("FAIL wr_uds: got %b expected 0011", {bus.nAS, bus.nUDS, bus.nLDS, bus.DOE}); end
        tick; tick;                         // edges 3, 4
        checks++; if (bus.Ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early: got %b expected 0", bus.Ack); end
        bus.nDTACK = 1'b0;
        tick;                               // edge 5: TERM
        checks++; if ({bus.DOE, bus.nUDS, bus.A, bus.DOut} !== {2'b10, 23'h012345, 16'h1234}) begin errors++; $display("FAIL wr_term_stable: got %h expected %h", {bus.DOE, bus.nUDS, bus.A, bus.DOut}, {2'b10, 23'h012345, 16'h1234}); end
        bus.nDTACK = 1'b1;
        tick;                               // edge 6
        checks++; if ({bus.Ack, bus.Err, bus.DOE, bus.nAS, bus.nUDS} !== 5'b10011) begin errors++; $display("FAIL wr_ack: got %b expected 10011", {bus.Ack, bus.Err, bus.DOE, bus.nAS, bus.nUDS}); end
        checks++; if (bus.RD !== 16'hBEEF) begin errors++; $display("FAIL wr_RD_kept: got %h expected BEEF", bus.RD); end
    endtask

    task automatic test_vpa;
        int nvma_edge = -1;
        int nvma_div  = -1;
        int ack_edge  = -1;
        int guard = 0;
        while (div_m != 4 && guard < 20) begin tick; guard++; end
        bus.nVPA = 1'b0;
        bus.DIn  = 16'h00A5;
        start_req(23'h000200, 1'b1, 2'b00, 16'h0000);  // divider 5 after edge 0
        tick; tick;                         // edge 2: VPA entry at divider 7
        checks++; if (div_m !== 7) begin errors++; $display("FAIL vpa_align: got %0d expected 7", div_m); end
        checks++; if (bus.E !== 1'b1) begin errors++; $display("FAIL vpa_E_high: got %b expected 1", bus.E); end
        for (int k = 3; k <= 30; k++) begin
            tick;
            if (nvma_edge < 0 && bus.nVMA === 1'b0) begin nvma_edge = k; nvma_div = div_m; end
            if (bus.Ack === 1'b1) begin ack_edge = k; break; end
        end
        bus.nVPA = 1'b1;
        checks++; if (nvma_edge !== 7 || nvma_div !== 2) begin errors++; $display("FAIL vpa_nvma: got edge %0d div %0d expected edge 7 div 2", nvma_edge, nvma_div); end
        checks++; if (ack_edge !== 16) begin errors++; $display("FAIL vpa_ack_edge: got %0d expected 16", ack_edge); end
        checks++; if ({bus.Err, bus.nVMA, bus.RD} !== {2'b01, 16'h00A5}) begin errors++; $display("FAIL vpa_data: got %h expected 100A5", {bus.Err, bus.nVMA, bus.RD}); end
    endtask

    task automatic test_timeout;
        int ack_edge = -1;
        bus.DIn = 16'h7777;
        start_req(23'h7FFFFF, 1'b1, 2'b01, 16'h0000);
        tick;
        checks++; if ({bus.nUDS, bus.nLDS} !== 2'b10) begin errors++; $display("FAIL to_be01: got %b expected 10", {bus.nUDS, bus.nLDS}); end
        for (int k = 2; k <= 40; k++) begin
            tick;
            if (bus.Ack === 1'b1) begin ack_edge = k; break; end
        end
        checks++; if (ack_edge !== 18) begin errors++; $display("FAIL to_ack_edge: got %0d expected 18", ack_edge); end
        checks++; if ({bus.Err, bus.nAS, bus.nUDS, bus.nLDS} !== 4'b1111) begin errors++; $display("FAIL to_err: got %b expected 1111", {bus.Err, bus.nAS, bus.nUDS, bus.nLDS}); end
        checks++; if (bus.RD !== 16'h00A5) begin errors++; $display("FAIL to_RD_kept: got %h expected 00A5", bus.RD); end
    endtask

    task automatic test_berr;
        start_req(23'h000300, 1'b1, 2'b11, 16'h0000);
        tick;                               // edge 1
        bus.nBERR  = 1'b0;
        bus.nDTACK = 1'b0;
        bus.DIn    = 16'hFFFF;
        tick;                               // edge 2
        bus.nBERR  = 1'b1;
        bus.nDTACK = 1'b1;
        tick;                               // edge 3
        checks++; if ({bus.Ack, bus.Err} !== 2'b11) begin errors++; $display("FAIL berr_ack: got %b expected 11", {bus.Ack, bus.Err}); end
        checks++; if (bus.RD !== 16'h00A5) begin errors++; $display("FAIL berr_RD_kept: got %h expected 00A5", bus.RD); end
    endtask

    task automatic test_dtack_vpa;
        start_req(23'h000400, 1'b1, 2'b11, 16'h0000);
        tick;
        bus.nDTACK = 1'b0;
        bus.nVPA   = 1'b0;
        bus.DIn    = 16'h5A5A;
        tick;
        bus.nDTACK = 1'b1;
        bus.nVPA   = 1'b1;
        tick;                               // edge 3
        checks++; if ({bus.Ack, bus.Err, bus.nVMA, bus.RD} !== {3'b101, 16'h5A5A}) begin errors++; $display("FAIL dv_prio: got %h expected 55A5A", {bus.Ack, bus.Err, bus.nVMA, bus.RD}); end
    endtask

    task automatic test_back_to_back;
        int acks[$];
        bus.nDTACK = 1'b0;
        bus.DIn    = 16'hCAFE;
        bus.ReqA   = 23'h000500;
        bus.ReqRnW = 1'b1;
        bus.ReqBE  = 2'b11;
        bus.Req    = 1'b1;
        tick;                               // edge 0
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (bus.Ack === 1'b1) acks.push_back(k);
            if (k == 4) bus.Req = 1'b0;
        end
        bus.nDTACK = 1'b1;
        checks++; if (acks.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", acks.size()); end
        else begin
            checks++; if (acks[0] !== 3 || acks[1] !== 7) begin errors++; $display("FAIL b2b_edges: got %0d,%0d expected 3,7", acks[0], acks[1]); end
        end
        checks++; if (bus.RD !== 16'hCAFE) begin errors++; $display("FAIL b2b_RD: got %h expected CAFE", bus.RD); end
    endtask

    task automatic test_reset_mid;
        int ack_seen = 0;
        start_req(23'h000600, 1'b1, 2'b11, 16'h0000);
        tick; tick; tick;                   // edge 3: in WAIT
        checks++; if (bus.nAS !== 1'b0) begin errors++; $display("FAIL rm_in_wait: got %b expected 0", bus.nAS); end
        RESET = 1'b1;
        tick;
        checks++; if ({bus.nAS, bus.nUDS, bus.nLDS, bus.Ack, bus.ReqRdy} !== 5'b11100) begin errors++; $display("FAIL rm_strobes: got %b expected 11100", {bus.nAS, bus.nUDS, bus.nLDS, bus.Ack, bus.ReqRdy}); end
        RESET = 1'b0;
        tick;
        checks++; if (bus.ReqRdy !== 1'b1) begin errors++; $display("FAIL rm_ReqRdy: got %b expected 1", bus.ReqRdy); end
        if (bus.Ack === 1'b1) ack_seen++;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (bus.Ack === 1'b1) ack_seen++;
        end
        checks++; if (ack_seen !== 0 || bus.RD !== 16'h0000) begin errors++; $display("FAIL rm_no_ack: got acks %0d RD %h expected 0 0000", ack_seen, bus.RD); end
    endtask

    initial begin
        RESET      = 1'b1;
        bus.Req    = 1'b0;
        bus.ReqA   = '0;
        bus.ReqRnW = 1'b1;
        bus.ReqBE  = 2'b11;
        bus.ReqWD  = '0;
        bus.DIn    = '0;
        bus.nDTACK = 1'b1;
        bus.nVPA   = 1'b1;
        bus.nBERR  = 1'b1;
        test_reset;
        test_read;
        test_write;
        test_vpa;
        test_timeout;
        test_berr;
        test_dtack_vpa;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
